call_scheduler: RTL and testbench

Upstream request stage of the elevator datapath. It latches floor-call buttons, chooses the next stop with a SCAN (keep-direction) policy, and drives the desired-floor bus consumed by `internalCalculator` as `F`. It reads back the current floor from the floor `counter` (`count`). It also sequences the door dwell at each stop.

---
 rtl/rideup_pkg.sv | 17 +
 rtl/next_floor_select.sv | 70 +++++++
 rtl/call_scheduler.sv | 149 ++++++++++++++
 tb/tb_call_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rideup_pkg.sv
// Shared types and constants for the elevator request path.
package rideup_pkg;

    // Default number of floors served by the request stage.
    localparam int FLOORS_DEFAULT = 10;

    // Floor index as carried on the floor/target buses.
    typedef logic [3:0] floor_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } sched_state_t;

endpackage

// File: rtl/next_floor_select.sv
// Combinational SCAN selector: nearest pending floor in the sweep direction,
// optionally reversing when nothing remains ahead.
module next_floor_select
    import rideup_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEFAULT
) (
    input  logic [FLOORS-1:0] pending,
    input  logic [3:0]        floor,
    input  logic              dir_up,
    input  logic              allow_flip,
    output logic              valid,
    output logic [3:0]        sel_floor,
    output logic              flip
);

    logic   above_found_s;
    logic   below_found_s;
    floor_t above_s;
    floor_t below_s;

    // Find the lowest pending floor above and the highest pending floor below.
    always_comb begin
        above_found_s = 1'b0;
        below_found_s = 1'b0;
        above_s       = 4'd0;
        below_s       = 4'd0;
        // Descending scan: the last hit is the lowest floor above.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            above_s       = (pending[i] && (floor_t'(i) > floor)) ? floor_t'(i) : above_s;
            above_found_s = above_found_s | (pending[i] && (floor_t'(i) > floor));
        end
        // Ascending scan: the last hit is the highest floor below.
        for (int i = 0; i < FLOORS; i++) begin
            below_s       = (pending[i] && (floor_t'(i) < floor)) ? floor_t'(i) : below_s;
            below_found_s = below_found_s | (pending[i] && (floor_t'(i) < floor));
        end
    end

    // Prefer the sweep direction; reverse only when allowed and needed.
    always_comb begin
        valid     = 1'b0;
        sel_floor = 4'd0;
        flip      = 1'b0;
        if (dir_up) begin
            if (above_found_s) begin
                valid     = 1'b1;
                sel_floor = above_s;
            end else if (allow_flip && below_found_s) begin
                valid     = 1'b1;
                sel_floor = below_s;
                flip      = 1'b1;
            end else begin
                valid     = 1'b0;
            end
        end else begin
            if (below_found_s) begin
                valid     = 1'b1;
                sel_floor = below_s;
            end else if (allow_flip && above_found_s) begin
                valid     = 1'b1;
                sel_floor = above_s;
                flip      = 1'b1;
            end else begin
                valid     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Request stage: latches floor calls, picks the next stop (SCAN), drives the
// desired-floor bus and sequences the door dwell at each stop.
module call_scheduler
    import rideup_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEFAULT,
    parameter int DWELL  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] call,
    input  logic [3:0]        floor,
    output logic [3:0]        target,
    output logic              door_open,
    output logic [FLOORS-1:0] pending,
    output logic              dir_up
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL - 1);
    localparam floor_t          LAST_FLOOR = floor_t'(FLOORS - 1);

    sched_state_t      state_r, state_s;
    logic [FLOORS-1:0] pending_r, pending_s;
    floor_t            target_r, target_s;
    logic              dir_up_r, dir_up_s;
    logic              door_open_r, door_open_s;
    logic [DW_W-1:0]   dwell_r, dwell_s;

    logic [FLOORS-1:0] floor_onehot_s;
    logic [FLOORS-1:0] clear_mask_s;
    logic              floor_valid_s;
    logic              here_s;
    logic              call_here_s;
    logic              allow_flip_s;
    logic              sel_valid_s;
    floor_t            sel_floor_s;
    logic              sel_flip_s;

    // An out-of-range floor yields an all-zero one-hot, so it never clears or matches.
    assign floor_valid_s  = (floor <= LAST_FLOOR);
    assign floor_onehot_s = {{(FLOORS-1){1'b0}}, 1'b1} << floor;
    assign here_s         = floor_valid_s & (|(pending_r & floor_onehot_s));
    assign call_here_s    = floor_valid_s & (|(call & floor_onehot_s));
    // Reversal is only considered when planning from rest.
    assign allow_flip_s   = (state_r == IDLE);

    next_floor_select #(
        .FLOORS (FLOORS)
    ) u_select (
        .pending    (pending_r),
        .floor      (floor),
        .dir_up     (dir_up_r),
        .allow_flip (allow_flip_s),
        .valid      (sel_valid_s),
        .sel_floor  (sel_floor_s),
        .flip       (sel_flip_s)
    );

    // Next-state, request latch and output decisions.
    always_comb begin
        state_s      = state_r;
        target_s     = target_r;
        dir_up_s     = dir_up_r;
        door_open_s  = door_open_r;
        dwell_s      = dwell_r;
        clear_mask_s = {FLOORS{1'b0}};
        if (!floor_valid_s) begin
            // Invalid floor reading: freeze the FSM and target, keep latching calls.
            state_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (here_s) begin
                        state_s      = DOOR;
                        door_open_s  = 1'b1;
                        dwell_s      = DWELL_LOAD;
                        target_s     = floor;
                        clear_mask_s = floor_onehot_s;
                    end else if (sel_valid_s) begin
                        state_s  = MOVE;
                        target_s = sel_floor_s;
                        dir_up_s = sel_flip_s ? ~dir_up_r : dir_up_r;
                    end else begin
                        // Nothing to do: F equals C so the datapath stays disabled.
                        target_s = floor;
                    end
                end
                MOVE: begin
                    if ((floor == target_r) && here_s) begin
                        state_s      = DOOR;
                        door_open_s  = 1'b1;
                        dwell_s      = DWELL_LOAD;
                        clear_mask_s = floor_onehot_s;
                    end else if (sel_valid_s) begin
                        // Forward-only re-evaluation picks up calls between floor and target.
                        target_s = sel_floor_s;
                    end else begin
                        // Nothing ahead any more: replan from rest.
                        state_s = IDLE;
                    end
                end
                DOOR: begin
                    clear_mask_s = floor_onehot_s;
                    target_s     = floor;
                    if (call_here_s) begin
                        dwell_s = DWELL_LOAD;
                    end else if (dwell_r == {DW_W{1'b0}}) begin
                        door_open_s = 1'b0;
                        state_s     = IDLE;
                    end else begin
                        dwell_s = dwell_r - 1'b1;
                    end
                end
                default: begin
                    state_s     = IDLE;
                    door_open_s = 1'b0;
                    dwell_s     = {DW_W{1'b0}};
                end
            endcase
        end
        pending_s = (pending_r | call) & ~clear_mask_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            pending_r   <= {FLOORS{1'b0}};
            target_r    <= 4'd0;
            dir_up_r    <= 1'b1;
            door_open_r <= 1'b0;
            dwell_r     <= {DW_W{1'b0}};
        end else begin
            state_r     <= state_s;
            pending_r   <= pending_s;
            target_r    <= target_s;
            dir_up_r    <= dir_up_s;
            door_open_r <= door_open_s;
            dwell_r     <= dwell_s;
        end
    end

    assign target    = target_r;
    assign door_open = door_open_r;
    assign pending   = pending_r;
    assign dir_up    = dir_up_r;

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: directed scenarios plus a random
// run compared against a behavioural SCAN model.
module tb_call_scheduler;

    logic       clk;
    logic       reset;
    logic [9:0] call;
    logic [3:0] floor;
    logic [3:0] target;
    logic       door_open;
    logic [9:0] pending;
    logic       dir_up;

    int checks = 0;
    int passes = 0;

    // Behavioural model: mode 0 = resting, 1 = travelling, 2 = doors open.
    bit [9:0] m_pend;
    int       m_target;
    bit       m_dir;
    bit       m_door;
    int       m_mode;
    int       m_dwell;

    call_scheduler #(.FLOORS(10), .DWELL(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .floor     (floor),
        .target    (target),
        .door_open (door_open),
        .pending   (pending),
        .dir_up    (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic void m_reset();
        m_pend = '0; m_target = 0; m_dir = 1'b1; m_door = 1'b0; m_mode = 0; m_dwell = 0;
    endfunction

    // SCAN choice from the model's request set.
    function automatic bit m_find(input int f, input bit up, input bit flip_ok, output int s, output bit fl);
        int above = -1;
        int below = -1;
        for (int i = 0; i < 10; i++) begin
            if (m_pend[i] && i > f && above < 0) above = i;
            if (m_pend[i] && i < f) below = i;
        end
        s = 0; fl = 1'b0;
        if (up) begin
            if (above >= 0) begin s = above; return 1'b1; end
            if (flip_ok && below >= 0) begin s = below; fl = 1'b1; return 1'b1; end
        end else begin
            if (below >= 0) begin s = below; return 1'b1; end
            if (flip_ok && above >= 0) begin s = above; fl = 1'b1; return 1'b1; end
        end
        return 1'b0;
    endfunction

    function automatic void m_step(input bit [9:0] c, input int f);
        bit [9:0] clr = '0;
        int s; bit fl;
        if (f < 10) begin
            if (m_mode == 0) begin
                if (m_pend[f]) begin
                    m_mode = 2; m_door = 1'b1; m_dwell = 3; m_target = f; clr[f] = 1'b1;
                end else if (m_find(f, m_dir, 1'b1, s, fl)) begin
                    m_mode = 1; m_target = s; if (fl) m_dir = !m_dir;
                end else m_target = f;
            end else if (m_mode == 1) begin
                if (f == m_target && m_pend[f]) begin
                    m_mode = 2; m_door = 1'b1; m_dwell = 3; clr[f] = 1'b1;
                end else if (m_find(f, m_dir, 1'b0, s, fl)) m_target = s;
                else m_mode = 0;
            end else begin
                clr[f] = 1'b1; m_target = f;
                if (c[f]) m_dwell = 3;
                else if (m_dwell == 0) begin m_door = 1'b0; m_mode = 0; end
                else m_dwell--;
            end
        end
        m_pend = (m_pend | c) & ~clr;
    endfunction

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cyc(input logic [9:0] c, input logic [3:0] f);
        call = c; floor = f;
        @(posedge clk);
        m_step(c, int'(f));
        #1;
    endtask

    task automatic drain(input logic [3:0] f, input int n);
        for (int i = 0; i < n; i++) cyc(10'h000, f);
    endtask

    task automatic test_reset();
        reset = 1'b1; call = 10'h000; floor = 4'd0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (target !== 4'd0 || door_open !== 1'b0 || dir_up !== 1'b1 || pending !== 10'h000)
                $display("FAIL reset_hold: got t=%0d d=%b u=%b p=%h want t=0 d=0 u=1 p=000", target, door_open, dir_up, pending);
            else passes++;
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(10'h000, 4'd0);
            checks++; if (target !== 4'd0 || door_open !== 1'b0 || dir_up !== 1'b1 || pending !== 10'h000)
                $display("FAIL reset_idle: got t=%0d d=%b u=%b p=%h want t=0 d=0 u=1 p=000", target, door_open, dir_up, pending);
            else passes++;
        end
    endtask

    task automatic test_single_call();
        int open_cycles;
        cyc(10'h020, 4'd0);
        checks++; if (pending !== 10'h020) $display("FAIL single_latch: got %h want 020", pending); else passes++;
        checks++; if (target !== 4'd0) $display("FAIL single_target_early: got %0d want 0", target); else passes++;
        cyc(10'h000, 4'd0);
        checks++; if (target !== 4'd5) $display("FAIL single_target: got %0d want 5", target); else passes++;
        for (int fl = 1; fl <= 4; fl++) cyc(10'h000, 4'(fl));
        checks++; if (door_open !== 1'b0) $display("FAIL single_no_early_door: got %b want 0", door_open); else passes++;
        cyc(10'h000, 4'd5);
        checks++; if (door_open !== 1'b1 || pending !== 10'h000)
            $display("FAIL single_arrive: got d=%b p=%h want d=1 p=000", door_open, pending);
        else passes++;
        open_cycles = 1;
        for (int i = 0; i < 8; i++) begin
            cyc(10'h000, 4'd5);
            if (door_open === 1'b1) open_cycles++;
        end
        checks++; if (open_cycles != 4) $display("FAIL single_dwell: got %0d cycles want 4", open_cycles); else passes++;
        checks++; if (target !== 4'd5 || door_open !== 1'b0)
            $display("FAIL single_rest: got t=%0d d=%b want t=5 d=0", target, door_open);
        else passes++;
    endtask

    task automatic test_retarget();
        cyc(10'h000, 4'd4); cyc(10'h000, 4'd3); cyc(10'h000, 4'd2);
        cyc(10'h080, 4'd2);
        cyc(10'h000, 4'd2);
        checks++; if (target !== 4'd7 || dir_up !== 1'b1)
            $display("FAIL retarget_start: got t=%0d u=%b want t=7 u=1", target, dir_up);
        else passes++;
        cyc(10'h010, 4'd2);
        cyc(10'h000, 4'd2);
        checks++; if (target !== 4'd4) $display("FAIL retarget_new: got %0d want 4", target); else passes++;
        cyc(10'h000, 4'd3); cyc(10'h000, 4'd4);
        checks++; if (door_open !== 1'b1 || pending !== 10'h080)
            $display("FAIL retarget_stop4: got d=%b p=%h want d=1 p=080", door_open, pending);
        else passes++;
        drain(4'd4, 4);
        checks++; if (door_open !== 1'b0) $display("FAIL retarget_close: got %b want 0", door_open); else passes++;
        cyc(10'h000, 4'd4);
        checks++; if (target !== 4'd7) $display("FAIL retarget_resume: got %0d want 7", target); else passes++;
        cyc(10'h000, 4'd5); cyc(10'h000, 4'd6); cyc(10'h000, 4'd7);
        checks++; if (door_open !== 1'b1 || pending !== 10'h000)
            $display("FAIL retarget_stop7: got d=%b p=%h want d=1 p=000", door_open, pending);
        else passes++;
        drain(4'd7, 4);
    endtask

    task automatic test_sweep_flip();
        cyc(10'h000, 4'd6);
        cyc(10'h104, 4'd6);
        cyc(10'h000, 4'd6);
        checks++; if (target !== 4'd8 || dir_up !== 1'b1)
            $display("FAIL sweep_first: got t=%0d u=%b want t=8 u=1", target, dir_up);
        else passes++;
        cyc(10'h000, 4'd7); cyc(10'h000, 4'd8);
        checks++; if (door_open !== 1'b1 || pending !== 10'h004)
            $display("FAIL sweep_stop8: got d=%b p=%h want d=1 p=004", door_open, pending);
        else passes++;
        drain(4'd8, 4);
        checks++; if (dir_up !== 1'b1) $display("FAIL sweep_dir_hold: got %b want 1", dir_up); else passes++;
        cyc(10'h000, 4'd8);
        checks++; if (target !== 4'd2 || dir_up !== 1'b0)
            $display("FAIL sweep_flip: got t=%0d u=%b want t=2 u=0", target, dir_up);
        else passes++;
        for (int fl = 7; fl >= 2; fl--) cyc(10'h000, 4'(fl));
        checks++; if (door_open !== 1'b1 || pending !== 10'h000)
            $display("FAIL sweep_stop2: got d=%b p=%h want d=1 p=000", door_open, pending);
        else passes++;
        drain(4'd2, 4);
    endtask

    task automatic test_door_extend();
        int open_cycles;
        cyc(10'h000, 4'd3);
        cyc(10'h008, 4'd3);
        cyc(10'h000, 4'd3);
        checks++; if (door_open !== 1'b1 || pending !== 10'h000)
            $display("FAIL extend_open: got d=%b p=%h want d=1 p=000", door_open, pending);
        else passes++;
        open_cycles = 1;
        cyc(10'h000, 4'd3); if (door_open === 1'b1) open_cycles++;
        cyc(10'h000, 4'd3); if (door_open === 1'b1) open_cycles++;
        cyc(10'h008, 4'd3); if (door_open === 1'b1) open_cycles++;
        checks++; if (pending !== 10'h000) $display("FAIL extend_absorb: got %h want 000", pending); else passes++;
        for (int i = 0; i < 8; i++) begin
            cyc(10'h000, 4'd3);
            if (door_open === 1'b1) open_cycles++;
        end
        checks++; if (open_cycles != 7) $display("FAIL extend_dwell: got %0d cycles want 7", open_cycles); else passes++;
    endtask

    task automatic test_reset_mid_move();
        cyc(10'h202, 4'd3);
        cyc(10'h000, 4'd3);
        checks++; if (target !== 4'd1) $display("FAIL midreset_move: got %0d want 1", target); else passes++;
        cyc(10'h000, 4'd2);
        #2 reset = 1'b1;
        #1;
        checks++; if (target !== 4'd0 || door_open !== 1'b0 || dir_up !== 1'b1 || pending !== 10'h000)
            $display("FAIL midreset_async: got t=%0d d=%b u=%b p=%h want t=0 d=0 u=1 p=000", target, door_open, dir_up, pending);
        else passes++;
        @(posedge clk); #1;
        checks++; if (pending !== 10'h000) $display("FAIL midreset_hold: got %h want 000", pending); else passes++;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_random();
        int cur;
        logic [9:0] c;
        logic [3:0] f;
        cur = 2;
        for (int n = 0; n < 800; n++) begin
            c = 10'h000;
            if ($urandom_range(0, 4) == 0) c[$urandom_range(0, 9)] = 1'b1;
            if ($urandom_range(0, 29) == 0) c = c | 10'($urandom);
            if (m_mode == 1 && (n % 2) == 0 && cur != m_target) cur = (m_target > cur) ? cur + 1 : cur - 1;
            f = ($urandom_range(0, 39) == 0) ? 4'd13 : 4'(cur);
            cyc(c, f);
            checks++; if (target !== 4'(m_target)) $display("FAIL rand_target n=%0d: got %0d want %0d", n, target, m_target); else passes++;
            checks++; if (door_open !== m_door) $display("FAIL rand_door n=%0d: got %b want %b", n, door_open, m_door); else passes++;
            checks++; if (dir_up !== m_dir) $display("FAIL rand_dir n=%0d: got %b want %b", n, dir_up, m_dir); else passes++;
            checks++; if (pending !== m_pend) $display("FAIL rand_pending n=%0d: got %h want %h", n, pending, m_pend); else passes++;
        end
    endtask

    initial begin
        reset = 1'b1; call = 10'h000; floor = 4'd0;
        test_reset();
        test_single_call();
        test_retarget();
        test_sweep_flip();
        test_door_extend();
        test_reset_mid_move();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
